// File: rtl/analogizer_pkg.sv
// rtl/analogizer_pkg.sv - shared constants, turbo-rate enum and NeoGeo map for the pad mapper
package analogizer_pkg;

    localparam int MAP_NEOGEO = 0;
    localparam int MAP_PASS   = 1;

    localparam int SNAC_UP     = 0;
    localparam int SNAC_DOWN   = 1;
    localparam int SNAC_LEFT   = 2;
    localparam int SNAC_RIGHT  = 3;
    localparam int SNAC_SELECT = 14;
    localparam int SNAC_START  = 15;

    typedef enum logic [1:0] {
        TURBO_OFF = 2'd0,
        TURBO_1F  = 2'd1,
        TURBO_2F  = 2'd2,
        TURBO_4F  = 2'd3
    } turbo_rate_e;

    // Frame-counter bits that must all be 1 before the autofire phase flips.
    function automatic logic [1:0] turbo_need(input turbo_rate_e rate);
        case (rate)
            TURBO_2F: turbo_need = 2'b01;
            TURBO_4F: turbo_need = 2'b11;
            default:  turbo_need = 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] neogeo_map(input logic [15:0] s);
        neogeo_map = {6'b0, s[SNAC_SELECT], s[SNAC_START], s[7:4],
                      s[SNAC_UP], s[SNAC_DOWN], s[SNAC_LEFT], s[SNAC_RIGHT]};
    endfunction

endpackage

// File: rtl/pad_debounce.sv
// rtl/pad_debounce.sv - per-bit sample-count debouncer for one 16-bit player word
module pad_debounce
    import analogizer_pkg::*;
#(
    parameter int DEBOUNCE_N = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        sample,
    input  logic        reload,
    input  logic [15:0] raw,
    output logic [15:0] stable
);

    generate
        if (DEBOUNCE_N == 0) begin : g_bypass
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          stable <= '0;
                else if (!ena)    stable <= '0;
                else if (sample)  stable <= raw;
            end
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_N + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);
            logic [CW-1:0] cnt [16];

            always_ff @(posedge clk or posedge rst) begin
                if (rst || !ena) begin
                    stable <= '0;
                    for (int b = 0; b < 16; b++) cnt[b] <= '0;
                end else if (sample) begin
                    if (reload) begin
                        stable <= raw;
                        for (int b = 0; b < 16; b++) cnt[b] <= '0;
                    end else begin
                        // A count that would reach DEBOUNCE_N commits instead, so it never wraps.
                        for (int b = 0; b < 16; b++) begin
                            if (raw[b] == stable[b]) begin
                                cnt[b] <= '0;
                            end else if (cnt[b] >= CNT_LAST) begin
                                stable[b] <= raw[b];
                                cnt[b]    <= '0;
                            end else begin
                                cnt[b] <= cnt[b] + CW'(1);
                            end
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/analogizer_pad_mapper.sv
// rtl/analogizer_pad_mapper.sv - selects, debounces, autofires and maps controller words per player
module analogizer_pad_mapper
    import analogizer_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAP_MODE    = 0,
    parameter int DEBOUNCE_N  = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ena,
    input  logic                      i_sample,
    input  logic [NUM_PLAYERS*16-1:0] i_snac_btn,
    input  logic [NUM_PLAYERS*16-1:0] i_pocket_btn,
    input  logic [NUM_PLAYERS-1:0]    i_src_sel,
    input  logic [15:0]               i_turbo_mask,
    input  logic [1:0]                i_turbo_rate,
    input  logic                      i_vsync,
    output logic [NUM_PLAYERS*16-1:0] o_player,
    output logic                      o_valid,
    output logic [NUM_PLAYERS-1:0]    o_changed
);

    logic [NUM_PLAYERS-1:0]    src_q;
    logic [NUM_PLAYERS-1:0]    reload_pend;
    logic [NUM_PLAYERS-1:0]    reload_now;
    logic                      vsync_q;
    logic [1:0]                frame_cnt;
    logic                      phase;
    logic                      s1_valid;
    logic [NUM_PLAYERS*16-1:0] stable_w;
    logic [NUM_PLAYERS*16-1:0] mapped;
    logic [15:0]               turbo_word;
    logic [1:0]                need;

    // A source switch seen between strobes is held until the next strobe consumes it.
    assign reload_now = reload_pend | (i_src_sel ^ src_q);
    assign need       = turbo_need(turbo_rate_e'(i_turbo_rate));

    generate
        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
            logic [15:0] raw;
            assign raw = i_src_sel[p] ? i_snac_btn[16*p +: 16] : i_pocket_btn[16*p +: 16];

            pad_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_debounce (
                .clk    (i_clk),
                .rst    (i_rst),
                .ena    (i_ena),
                .sample (i_sample),
                .reload (reload_now[p]),
                .raw    (raw),
                .stable (stable_w[16*p +: 16])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_q       <= '0;
            reload_pend <= '0;
            vsync_q     <= 1'b0;
            frame_cnt   <= 2'd0;
            phase       <= 1'b1;
            s1_valid    <= 1'b0;
        end else begin
            src_q    <= i_src_sel;
            vsync_q  <= i_vsync;
            s1_valid <= i_ena & i_sample;
            if (!i_ena || i_sample) reload_pend <= '0;
            else                    reload_pend <= reload_now;

            if (turbo_rate_e'(i_turbo_rate) == TURBO_OFF) begin
                phase     <= 1'b1;
                frame_cnt <= 2'd0;
            end else if (i_vsync && !vsync_q) begin
                if ((frame_cnt & need) == need) begin
                    phase     <= ~phase;
                    frame_cnt <= 2'd0;
                end else begin
                    frame_cnt <= frame_cnt + 2'd1;
                end
            end
        end
    end

    always_comb begin
        mapped     = '0;
        turbo_word = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            turbo_word = stable_w[16*p +: 16] & ~(i_turbo_mask & {16{~phase}});
            mapped[16*p +: 16] = (MAP_MODE == MAP_NEOGEO) ? neogeo_map(turbo_word) : turbo_word;
        end
    end

    // Output word tracks turbo continuously; valid/changed only mark debounced sample updates.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_player  <= '0;
            o_valid   <= 1'b0;
            o_changed <= '0;
        end else if (!i_ena) begin
            o_player  <= '0;
            o_valid   <= 1'b0;
            o_changed <= '0;
        end else begin
            o_player <= mapped;
            o_valid  <= s1_valid;
            for (int p = 0; p < NUM_PLAYERS; p++)
                o_changed[p] <= s1_valid && (mapped[16*p +: 16] != o_player[16*p +: 16]);
        end
    end

endmodule

// File: tb/tb_analogizer_pad_mapper.sv
// tb/tb_analogizer_pad_mapper.sv - directed self-checking bench for analogizer_pad_mapper
module tb_analogizer_pad_mapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        sample;
    logic [31:0] snac;
    logic [31:0] pocket;
    logic [1:0]  src_sel;
    logic [15:0] mask;
    logic [1:0]  rate;
    logic        vsync;

    logic [31:0] player_a, player_b;
    logic        valid_a, valid_b;
    logic [1:0]  changed_a, changed_b;

    int checks   = 0;
    int failures = 0;
    int changed_cnt_a = 0;
    int snap;

    always #5 clk = ~clk;

    always @(negedge clk) if (|changed_a) changed_cnt_a++;

    analogizer_pad_mapper #(.NUM_PLAYERS(2), .MAP_MODE(0), .DEBOUNCE_N(3)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_sample(sample),
        .i_snac_btn(snac), .i_pocket_btn(pocket), .i_src_sel(src_sel),
        .i_turbo_mask(mask), .i_turbo_rate(rate), .i_vsync(vsync),
        .o_player(player_a), .o_valid(valid_a), .o_changed(changed_a)
    );

    analogizer_pad_mapper #(.NUM_PLAYERS(2), .MAP_MODE(1), .DEBOUNCE_N(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_sample(sample),
        .i_snac_btn(snac), .i_pocket_btn(pocket), .i_src_sel(src_sel),
        .i_turbo_mask(mask), .i_turbo_rate(rate), .i_vsync(vsync),
        .o_player(player_b), .o_valid(valid_b), .o_changed(changed_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample_burst(input int n);
        @(posedge clk); #1 sample = 1'b1;
        repeat (n) @(posedge clk);
        #1 sample = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 ena = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; sample = 1'b0; snac = '0; pocket = '0;
        src_sel = 2'b11; mask = '0; rate = 2'd0; vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_player", {32'h0, player_a}, 64'h0);
        check("reset_valid", {63'h0, valid_a}, 64'h0);
        check("reset_changed", {62'h0, changed_a}, 64'h0);
        release_reset();

        // glitch: two high samples then low must never commit
        snap = changed_cnt_a;
        snac = 32'h0000_0001;
        sample_burst(1);
        sample_burst(1);
        snac = 32'h0;
        sample_burst(1);
        check("glitch_player", {32'h0, player_a}, 64'h0);
        check("glitch_no_changed", 64'(changed_cnt_a - snap), 64'h0);

        // three strobes commit bit0 -> NeoGeo bit3
        snac = 32'h0000_0001;
        sample_burst(1);
        check("deb_s1_a", {32'h0, player_a}, 64'h0);
        check("bypass_s1_b", {32'h0, player_b}, 64'h0000_0001);
        check("bypass_changed_b", {62'h0, changed_b}, 64'h1);
        sample_burst(1);
        check("deb_s2_a", {32'h0, player_a}, 64'h0);
        check("deb_s2_changed", {62'h0, changed_a}, 64'h0);
        sample_burst(1);
        check("deb_s3_a", {32'h0, player_a}, 64'h0000_0008);
        check("deb_s3_valid", {63'h0, valid_a}, 64'h1);
        check("deb_s3_changed", {62'h0, changed_a}, 64'h1);
        @(posedge clk); #1;
        check("valid_one_cycle", {63'h0, valid_a}, 64'h0);
        check("changed_one_cycle", {62'h0, changed_a}, 64'h0);

        // back-to-back strobes, NeoGeo and passthrough maps
        snac = 32'h0000_C0F5;
        sample_burst(3);
        check("map_neogeo", {32'h0, player_a}, 64'h0000_03FA);
        check("map_pass", {32'h0, player_b}, 64'h0000_C0F5);
        check("burst_valid", {63'h0, valid_a}, 64'h1);

        // autofire on bit0, toggling every second vsync edge
        mask = 16'h0001; rate = 2'd2;
        vsync_pulse();
        check("turbo_r1", {32'h0, player_a}, 64'h0000_03FA);
        vsync_pulse();
        check("turbo_r2", {32'h0, player_a}, 64'h0000_03F2);
        check("turbo_r2_pass", {32'h0, player_b}, 64'h0000_C0F4);
        check("turbo_no_valid", {63'h0, valid_a}, 64'h0);
        vsync_pulse();
        check("turbo_r3", {32'h0, player_a}, 64'h0000_03F2);
        vsync_pulse();
        check("turbo_r4", {32'h0, player_a}, 64'h0000_03FA);
        vsync_pulse();
        vsync_pulse();
        check("turbo_r6", {32'h0, player_a}, 64'h0000_03F2);
        rate = 2'd0;
        @(posedge clk); @(posedge clk); #1;
        check("turbo_off_held", {32'h0, player_a}, 64'h0000_03FA);
        mask = 16'h0;

        // source switch on player 1 reloads without debounce
        pocket = 32'h0010_0000;
        src_sel = 2'b01;
        @(posedge clk); #1;
        sample_burst(1);
        check("srcsel_reload_a", {32'h0, player_a}, 64'h0010_03FA);
        check("srcsel_changed", {62'h0, changed_a}, 64'h2);
        check("srcsel_reload_b", {32'h0, player_b}, 64'h0010_C0F5);

        // disable clears and ignores strobes
        ena = 1'b0;
        @(posedge clk); #1;
        check("ena_off_player", {32'h0, player_a}, 64'h0);
        sample_burst(1);
        check("ena_off_valid", {63'h0, valid_a}, 64'h0);
        ena = 1'b1;
        sample_burst(1);
        check("ena_on_counting", {32'h0, player_a}, 64'h0);
        check("ena_on_bypass", {32'h0, player_b}, 64'h0010_C0F5);

        // reset mid-count discards partial counts
        sample_burst(1);
        @(posedge clk); #1 rst = 1'b1; ena = 1'b0;
        #1;
        check("rst_async_a", {32'h0, player_a}, 64'h0);
        check("rst_async_b", {32'h0, player_b}, 64'h0);
        release_reset();
        sample_burst(1);
        sample_burst(1);
        check("rst_recount_s2", {32'h0, player_a}, 64'h0);
        sample_burst(1);
        check("rst_recount_s3", {32'h0, player_a}, 64'h0010_03FA);
        check("rst_recount_changed", {62'h0, changed_a}, 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/analogizer_pad_mapper.md
ANALOGIZER_PAD_MAPPER -- requirements
Module: analogizer_pad_mapper

Interface
- REQ-001: Parameter NUM_PLAYERS, default 2, number of player channels (1..4).
- REQ-002: Parameter MAP_MODE, default 0, 0 = NeoGeo 10-bit map, 1 = 16-bit passthrough.
- REQ-003: Parameter DEBOUNCE_N, default 3, consecutive differing samples before a button changes state; 0 = bypass.
- REQ-004: i_clk  in  1  single core clock, all logic rising-edge.
- REQ-005: i_rst  in  1  asynchronous, active-high reset.
- REQ-006: i_ena  in  1  block enable.
- REQ-007: i_sample  in  1  one-cycle strobe, new controller sample available.
- REQ-008: i_snac_btn  in  NUM_PLAYERS*16  SNAC button states, player p at [16p+15:16p], active-high.
- REQ-009: i_pocket_btn  in  NUM_PLAYERS*16  Pocket pad states, same layout.
- REQ-010: i_src_sel  in  NUM_PLAYERS  per player source, 1 = SNAC, 0 = Pocket.
- REQ-011: i_turbo_mask  in  16  source-bit positions subject to autofire.
- REQ-012: i_turbo_rate  in  2  0 = off, 1/2/3 = phase toggles every 1/2/4 frames.
- REQ-013: i_vsync  in  1  frame sync level, active-high.
- REQ-014: o_player  out  NUM_PLAYERS*16  mapped core button words.
- REQ-015: o_valid  out  1  one-cycle pulse, o_player updated this cycle.
- REQ-016: o_changed  out  NUM_PLAYERS  one-cycle per-player flag, word differs from previous, coincident with o_valid.

Function
- REQ-017: Raw word per player SHALL be i_snac_btn slice when i_src_sel[p]=1, else i_pocket_btn slice.
- REQ-018: On each i_sample, per bit: raw equal to stable -> counter cleared; raw differs -> counter+1; counter reaching DEBOUNCE_N -> stable takes raw, counter cleared.
- REQ-019: DEBOUNCE_N=0 SHALL load stable from raw on every i_sample.
- REQ-020: Counters SHALL saturate at DEBOUNCE_N, width clog2(DEBOUNCE_N+1), never wrap.
- REQ-021: A change of i_src_sel[p] (registered compare) SHALL load stable[p] from the new raw word and clear its counters on the next i_sample; reload wins over normal debounce.
- REQ-022: Rising edge of i_vsync (registered edge detect) SHALL advance a 2-bit frame counter; phase toggles when counter bits required by rate all equal 1, then counter clears.
- REQ-023: i_turbo_rate=0 SHALL hold phase at 1; phase reset value is 1.
- REQ-024: Turbo-masked bits SHALL be stable AND phase; unmasked bits pass stable unchanged.
- REQ-025: MAP_MODE 0: out[15:10]=0, out[9]=s[14], out[8]=s[15], out[7:4]=s[7:4], out[3]=s[0], out[2]=s[1], out[1]=s[2], out[0]=s[3].
- REQ-026: MAP_MODE 1: out = turbo-applied stable word unchanged.
- REQ-027: Latency: o_player and o_valid SHALL update exactly 2 cycles after the i_sample cycle (stage 1 debounce, stage 2 map/output).
- REQ-028: Turbo phase change without i_sample SHALL update o_player within 2 cycles, without o_valid.
- REQ-029: i_sample on consecutive cycles SHALL be accepted each cycle, no drop.
- REQ-030: i_ena=0 SHALL force o_player=0, o_valid=0, o_changed=0, clear counters and stable, and ignore i_sample.

Reset
- REQ-031: i_rst SHALL asynchronously set o_player=0, o_valid=0, o_changed=0, stable=0, counters=0, frame counter=0, phase=1, vsync and src_sel history=0.
- REQ-032: First i_sample after reset deassert SHALL be processed normally; reset mid-debounce discards partial counts.

Structure
- REQ-033: Shared package analogizer_pkg SHALL hold MAP_NEOGEO/MAP_PASS constants, SNAC bit-index constants, turbo-rate enum.
- REQ-034: Sub-module pad_debounce (one 16-bit player, DEBOUNCE_N parameter) SHALL be instantiated NUM_PLAYERS times via generate.

Verification
- REQ-035: DEBOUNCE_N=3, SNAC p0 bit0 set, 3 i_sample strobes -> o_player[3]=1 two cycles after third strobe, o_changed[0]=1; not after second.
- REQ-036: Bit0 glitch high for 2 samples then low -> o_player stays 0x0000, o_changed never asserted.
- REQ-037: MAP_MODE 0, stable=0xC0F5 -> o_player=0x03FA; MAP_MODE 1 -> 0xC0F5.
- REQ-038: i_turbo_mask=0x0001, rate=2, bit0 held -> o_player[3] toggles every second vsync rising edge; rate=0 -> held 1.
- REQ-039: i_src_sel[1] 1->0 with Pocket p1=0x0010 -> o_player p1 bit4 set after one i_sample, no debounce delay.
- REQ-040: i_rst asserted mid-count (counter=2) -> all outputs 0 immediately, phase=1; next 3 samples required to register press.
